store_merge_unit: RTL and testbench

Store-side counterpart of the writeback load-split path: accepts byte/halfword/word store requests from the MEM stage and writes them into a word-wide synchronous data RAM that has no byte enables. Word stores are written directly. Byte and halfword stores perform a read-modify-write: read the word, merge the new lane(s), then write the word back. Sits between the MEM-stage store controls and the data RAM port; stalls the pipeline through a valid/ready handshake while a request is in flight.

---
 rtl/store_merge_unit_pkg.sv | 22 ++
 rtl/store_lane_merge.sv | 27 ++
 rtl/store_merge_unit.sv | 112 +++++++++++
 tb/tb_store_merge_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/store_merge_unit_pkg.sv
// store_merge_unit_pkg: shared store-type codes, FSM states and the alignment check.
package store_merge_unit_pkg;

    localparam logic [1:0] ST_SB  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SW  = 2'b10;
    localparam logic [1:0] ST_INV = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        ERR
    } state_t;

    // Misaligned halfword/word stores and the reserved type code are rejected.
    function automatic logic store_is_err(input logic [1:0] st, input logic [1:0] lane);
        return (st == ST_INV) || (st == ST_SH && lane[0]) || (st == ST_SW && lane != 2'b00);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: inserts right-aligned store data into the addressed little-endian lanes of a word.
//   old_word  in  32  word read from RAM
//   new_data  in  32  right-aligned store data
//   st_type   in  2   store type (SB/SH/SW)
//   lane      in  2   Addr[1:0]
//   merged    out 32  word to write back
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  st_type,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        if (st_type == ST_SB)
            merged[{lane, 3'b000} +: 8] = new_data[7:0];
        else if (st_type == ST_SH)
            merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
        else if (st_type == ST_SW)
            merged = new_data;
    end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: writes SB/SH/SW stores into a word-wide RAM without byte enables (RMW for sub-word).
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   store request handshake (ready only in IDLE)
//   StoreType/Addr/WriteData  store request fields
//   mem_addr/mem_rd_en/mem_rdata/mem_we/mem_wdata  data RAM port
//   done                  pulse when the RAM write is issued
//   store_err             pulse on a misaligned or invalid request
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        StoreType,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              store_err
);

    state_t      state;
    logic [1:0]  st_q;
    logic [1:0]  lane_q;
    logic [31:0] data_q;
    logic [31:0] merged;
    logic        unused_addr;

    // Byte address bits above the RAM word range are deliberately ignored.
    assign unused_addr = ^Addr[31:ADDR_W+2];

    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (data_q),
        .st_type  (st_q),
        .lane     (lane_q),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            done      <= 1'b0;
            store_err <= 1'b0;
            st_q      <= ST_SB;
            lane_q    <= '0;
            data_q    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    req_ready <= 1'b0;
                    st_q      <= StoreType;
                    lane_q    <= Addr[1:0];
                    data_q    <= WriteData;
                    if (store_is_err(StoreType, Addr[1:0])) begin
                        store_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        mem_addr <= Addr[ADDR_W+1:2];
                        if (StoreType == ST_SW) begin
                            mem_wdata <= WriteData;
                            mem_we    <= 1'b1;
                            done      <= 1'b1;
                            state     <= WR;
                        end else begin
                            mem_rd_en <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= MRG;
                end
                MRG: begin
                    mem_wdata <= merged;
                    mem_we    <= 1'b1;
                    done      <= 1'b1;
                    state     <= WR;
                end
                WR: begin
                    mem_we    <= 1'b0;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                ERR: begin
                    store_err <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed self-checking bench for store_merge_unit.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  StoreType = 2'b00;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata = '0;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        done;
    logic        store_err;

    logic [31:0] ram_word = 32'h1122_3344;
    int          tests = 0;
    int          fails = 0;
    int          rd_cnt = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    int          overlap = 0;
    int          rd0, we0, dn0;

    store_merge_unit #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .StoreType (StoreType),
        .Addr      (Addr),
        .WriteData (WriteData),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .done      (done),
        .store_err (store_err)
    );

    always #5 clk = ~clk;

    // Single-word RAM model: read data appears the cycle after the strobe.
    always @(posedge clk) if (mem_rd_en) mem_rdata <= ram_word;

    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (mem_we) we_cnt++;
        if (done) done_cnt++;
        if (mem_rd_en && mem_we) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
        StoreType = st;
        Addr      = a;
        WriteData = d;
        req_valid = 1'b1;
    endtask

    task automatic rmw(input string tag, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] d, input logic [9:0] wa, input logic [31:0] exp);
        issue(st, a, d);
        chk({tag, "_ready_c0"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk({tag, "_rd_c1"}, 32'(mem_rd_en), 32'd1);
        chk({tag, "_addr_c1"}, 32'(mem_addr), 32'(wa));
        chk({tag, "_ready_c1"}, 32'(req_ready), 32'd0);
        step();
        chk({tag, "_idle_c2"}, {30'd0, mem_rd_en, mem_we}, 32'd0);
        step();
        chk({tag, "_we_c3"}, {30'd0, mem_we, done}, 32'd3);
        chk({tag, "_wdata_c3"}, mem_wdata, exp);
        chk({tag, "_addr_c3"}, 32'(mem_addr), 32'(wa));
        step();
        chk({tag, "_ready_c4"}, {30'd0, req_ready, mem_we}, 32'd2);
    endtask

    task automatic err_req(input string tag, input logic [1:0] st, input logic [31:0] a);
        rd0 = rd_cnt;
        we0 = we_cnt;
        issue(st, a, 32'hFFFF_FFFF);
        step();
        req_valid = 1'b0;
        chk({tag, "_err_c1"}, {29'd0, store_err, mem_rd_en, mem_we}, 32'd4);
        chk({tag, "_ready_c1"}, 32'(req_ready), 32'd0);
        step();
        chk({tag, "_ready_c2"}, {30'd0, req_ready, store_err}, 32'd2);
        step();
        chk({tag, "_no_ram"}, 32'((rd_cnt - rd0) + (we_cnt - we0)), 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ctl", {28'd0, mem_rd_en, mem_we, done, store_err}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        rd0 = rd_cnt;
        we0 = we_cnt;
        repeat (5) step();
        chk("idle_no_ram", 32'((rd_cnt - rd0) + (we_cnt - we0)), 32'd0);

        // Word store
        issue(2'b10, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("sw_ready_c0", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("sw_we_c1", {29'd0, mem_we, done, mem_rd_en}, 32'd6);
        chk("sw_addr_c1", 32'(mem_addr), 32'd4);
        chk("sw_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
        chk("sw_ready_c1", 32'(req_ready), 32'd0);
        step();
        chk("sw_ready_c2", {30'd0, req_ready, mem_we}, 32'd2);

        // Sub-word read-modify-writes
        rmw("sb3", 2'b00, 32'h0000_0013, 32'h0000_00AB, 10'd4, 32'hAB22_3344);
        rmw("sh1", 2'b01, 32'h0000_0006, 32'h0000_CAFE, 10'd1, 32'hCAFE_3344);
        rmw("sh0", 2'b01, 32'h0000_0004, 32'h1234_BEEF, 10'd1, 32'h1122_BEEF);
        rmw("sb0", 2'b00, 32'h0000_0020, 32'h0000_FF55, 10'd8, 32'h1122_3355);
        ram_word = 32'hA5A5_A5A5;
        rmw("sb1", 2'b00, 32'h0000_0031, 32'h0000_003C, 10'd12, 32'hA5A5_3CA5);
        ram_word = 32'h1122_3344;

        // Error requests
        err_req("sh_mis", 2'b01, 32'h0000_0005);
        err_req("inv", 2'b11, 32'h0000_0000);
        err_req("sw_mis", 2'b10, 32'h0000_0002);

        // Second SW held during an SB in flight
        issue(2'b00, 32'h0000_0008, 32'h0000_0077);
        step();
        issue(2'b10, 32'h0000_0040, 32'h55AA_55AA);
        chk("b2b_ready_c1", 32'(req_ready), 32'd0);
        step();
        chk("b2b_ready_c2", 32'(req_ready), 32'd0);
        step();
        chk("b2b_ready_c3", 32'(req_ready), 32'd0);
        chk("b2b_sb_wdata_c3", mem_wdata, 32'h1122_3377);
        chk("b2b_sb_addr_c3", 32'(mem_addr), 32'd2);
        step();
        chk("b2b_ready_c4", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("b2b_sw_we_c5", {30'd0, mem_we, done}, 32'd3);
        chk("b2b_sw_addr_c5", 32'(mem_addr), 32'h10);
        chk("b2b_sw_wdata_c5", mem_wdata, 32'h55AA_55AA);
        step();

        // Reset during MRG drops the write
        we0 = we_cnt;
        dn0 = done_cnt;
        issue(2'b00, 32'h0000_0010, 32'h0000_0099);
        step();
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_ctl", {28'd0, mem_rd_en, mem_we, done, store_err}, 32'd0);
        chk("arst_wdata", mem_wdata, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("arst_no_we", 32'(we_cnt - we0), 32'd0);
        chk("arst_no_done", 32'(done_cnt - dn0), 32'd0);
        chk("arst_ready_after", 32'(req_ready), 32'd1);

        chk("rd_we_overlap", 32'(overlap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
